sram_arbiter: RTL
=================

# sram_arbiter

Two-port arbiter that shares one single-port synchronous SRAM (1-cycle read latency, write-first read-back) between the display pixel fetcher (port A, read-only, high priority) and the game-logic engine (port B, read/write). It sits between those requesters and the SRAM instance. It issues at most one SRAM access per clock, routes read data back to the owner with a valid strobe, and bounds port B's wait time with a starvation counter.

## Interface
- DATA_WIDTH, 8, SRAM word width
- ADDR_WIDTH, 16, SRAM address width
- STARVE_LIMIT, 4, consecutive cycles B may be denied before it is forced to win (legal range 1..255)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- a_req  in  1  port A read request; held with a_addr stable until granted
- a_addr  in  ADDR_WIDTH  port A read address
- a_gnt  out  1  combinational; A's access is issued this cycle
- a_rvalid  out  1  registered; a_rdata valid this cycle
- a_rdata  out  DATA_WIDTH  read data for A (sram_rdata routed)
- b_req  in  1  port B request; held with b_we/b_addr/b_wdata stable until granted
- b_we  in  1  1 = write, 0 = read
- b_addr  in  ADDR_WIDTH  port B address
- b_wdata  in  DATA_WIDTH  port B write data
- b_gnt  out  1  combinational; B's access is issued this cycle
- b_rvalid  out  1  registered; b_rdata valid (B reads only)
- b_rdata  out  DATA_WIDTH  read data for B
- sram_en  out  1  SRAM enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM registered read data

## Operation
- A transfer happens on the rising edge where req and gnt are both high. Requesters must not change fields or drop req before the grant. The arbiter does not check this.
- Priority: the default is A over B. When force_b is set (wait_cnt == STARVE_LIMIT) and b_req is high, B wins even if a_req is high.
- wait_cnt (8 bit):
  - Cleared when b_req is low or B is granted.
  - Otherwise incremented on each edge where b_req is high and B is not granted.
  - Saturates at STARVE_LIMIT.
- At most one of a_gnt and b_gnt is high. When neither req is high, both are low.
- SRAM drive, combinational from the winner:
  - A wins: sram_en=1, sram_we=0, sram_addr=a_addr.
  - B wins: sram_en=1, sram_we=b_we, sram_addr=b_addr, sram_wdata=b_wdata.
  - Idle: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
- Return tag: a 2-bit register records {A read, B read} issued on each edge. a_rvalid and b_rvalid are that tag.
  - a_rdata = b_rdata = sram_rdata. Only the matching rvalid qualifies the data.
- B writes never produce b_rvalid. The SRAM's write-first echo on sram_rdata is ignored.
- Back-to-back accesses are allowed every cycle. Throughput is 1 access/clk.

## Timing
- Reset values: a_rvalid=0, b_rvalid=0, wait_cnt=0, tag=0.
- While reset is high, a_gnt=b_gnt=0 and sram_en=sram_we=0. No access is issued.
- Read latency: accepted at edge N → rvalid high for exactly the cycle between edges N and N+1, with data from that address.
- A read accepted at the edge before reset is asserted still shows rvalid in the following cycle. The edge where reset is sampled high clears it.
- Both requesting, force_b clear → A granted. wait_cnt increments at that edge.
- B continuously denied for STARVE_LIMIT cycles:
  - In the next cycle, b_gnt=1 and a_gnt=0.
  - A retries and is granted the following cycle, if B's grant cleared the counter.
- B write followed by B or A read of the same address in the next cycle returns the new data.

## Test plan
- Reset: hold reset 3 cycles with a_req=b_req=1 → a_gnt=b_gnt=sram_en=0. After reset drops, both rvalids are 0 until the first grant.
- A reads alone: a_req=1 with a_addr=0x0000,0x0001,0x0002 on consecutive cycles, RAM preloaded with 0x11,0x22,0x33 → a_gnt=1 each cycle. a_rvalid=1 one cycle later each time, with a_rdata 0x11,0x22,0x33.
- B write then read: b_we=1, addr=0x0100, wdata=0x5A granted, then b_we=0 same address → b_rvalid=1 exactly once, with b_rdata=0x5A. No b_rvalid for the write.
- Starvation, STARVE_LIMIT=4: a_req held high continuously and b_req high from cycle 0 (read of 0x0200):
  - a_gnt for cycles 0–3, b_gnt at cycle 4, then a_gnt resumes at cycle 5.
  - b_rvalid at cycle 5.
- Contention, both requesting reads every cycle for 20 cycles → exactly one grant per cycle. B receives 1 of every STARVE_LIMIT+1 grants. Each rvalid matches the port granted the previous cycle.
- Reset mid-traffic: A read granted at cycle N, reset high in cycle N+1 → a_rvalid=1 in cycle N+1, then 0. wait_cnt is 0 after reset.

Source files
------------

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between a high-priority read-only
// pixel fetcher (A) and a read/write game-logic engine (B), with starvation bound for B.
module sram_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  a_req_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    output logic                  a_gnt_o,
    output logic                  a_rvalid_o,
    output logic [DATA_WIDTH-1:0] a_rdata_o,

    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    output logic                  b_gnt_o,
    output logic                  b_rvalid_o,
    output logic [DATA_WIDTH-1:0] b_rdata_o,

    output logic                  sram_en_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] wait_q, wait_d;
    logic [1:0] tag_q, tag_d;   // {A read issued, B read issued} on the last edge
    logic       force_b;
    logic       a_win, b_win;

    assign force_b = (wait_q == LIMIT);

    // A normally wins; B overrides once it has been denied STARVE_LIMIT times in a row.
    always_comb begin
        b_win = 1'b0;
        a_win = 1'b0;
        if (!reset_i) begin
            b_win = b_req_i && (!a_req_i || force_b);
            a_win = a_req_i && !b_win;
        end
    end

    assign a_gnt_o = a_win;
    assign b_gnt_o = b_win;

    always_comb begin
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (a_win) begin
            sram_en_o   = 1'b1;
            sram_addr_o = a_addr_i;
        end else if (b_win) begin
            sram_en_o    = 1'b1;
            sram_we_o    = b_we_i;
            sram_addr_o  = b_addr_i;
            sram_wdata_o = b_wdata_i;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!b_req_i || b_win) begin
            wait_d = '0;
        end else if (wait_q != LIMIT) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // B writes are not tagged, so the write-first echo never reaches B.
    assign tag_d = {a_win, b_win & ~b_we_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wait_q <= '0;
            tag_q  <= '0;
        end else begin
            wait_q <= wait_d;
            tag_q  <= tag_d;
        end
    end

    assign a_rvalid_o = tag_q[1];
    assign b_rvalid_o = tag_q[0];
    assign a_rdata_o  = sram_rdata_i;
    assign b_rdata_o  = sram_rdata_i;

endmodule
